// File: rtl/seg_display_arbiter_if.sv
// Display-sharing bundle: requester side (master) drives req/req_data, arbiter side (slave) drives ownership and display word.
interface seg_display_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      grant;
    logic [IDW-1:0]       owner_id;
    logic [31:0]          disp_data;
    logic                 disp_valid;
    logic                 switch_pulse;

    modport master (
        output req, req_data,
        input  grant, owner_id, disp_data, disp_valid, switch_pulse
    );

    modport slave (
        input  req, req_data,
        output grant, owner_id, disp_data, disp_valid, switch_pulse
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 7-segment display word with a minimum dwell; ownership and data registered, 1-cycle latency.
// No backpressure: requesters hold req as a level while they want the display; losers simply wait.
module seg_display_arbiter #(
    parameter int          NREQ      = 4,
    parameter int          MIN_DWELL = 100_000_000,
    parameter logic [31:0] IDLE_WORD = 32'h0
) (
    input logic clk,
    input logic reset,
    seg_display_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam logic [DW-1:0] DWELL_RELOAD = DW'(MIN_DWELL - 1);
    localparam logic [DW-1:0] DWELL_ONE    = DW'(1);
    localparam logic [IW-1:0] PTR_RESET    = IW'(NREQ - 1);

    typedef enum logic {S_IDLE, S_OWNED} state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_owner, w_owner_nxt;
    logic [IW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [IW-1:0]   w_pick, w_idx;
    logic            w_pick_vld;
    logic [DW-1:0]   r_dwell, w_dwell_nxt;
    logic [31:0]     r_disp_data, w_disp_data_nxt;
    logic            r_switch, w_switch_nxt;
    logic [NREQ-1:0] w_owner_oh, w_cand;

    always_comb begin
        w_owner_oh = '0;
        if (r_state == S_OWNED)
            w_owner_oh[r_owner] = 1'b1;
    end

    // The current owner is masked so a handover only ever goes to someone else.
    assign w_cand = bus.req & ~w_owner_oh;

    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        w_idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_pick_vld && w_cand[w_idx]) begin
                w_pick_vld = 1'b1;
                w_pick     = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_dwell_nxt  = (r_dwell == '0) ? '0 : r_dwell - DWELL_ONE;
        w_switch_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_dwell_nxt = '0;
                if (w_pick_vld) begin
                    w_state_nxt  = S_OWNED;
                    w_owner_nxt  = w_pick;
                    w_rr_ptr_nxt = w_pick;
                    w_dwell_nxt  = DWELL_RELOAD;
                    w_switch_nxt = 1'b1;
                end
            end
            S_OWNED: begin
                // A release always goes through IDLE, even with others waiting.
                if (!bus.req[r_owner]) begin
                    w_state_nxt  = S_IDLE;
                    w_owner_nxt  = '0;
                    w_dwell_nxt  = '0;
                    w_switch_nxt = 1'b1;
                end else if (r_dwell == '0 && w_pick_vld) begin
                    w_owner_nxt  = w_pick;
                    w_rr_ptr_nxt = w_pick;
                    w_dwell_nxt  = DWELL_RELOAD;
                    w_switch_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_disp_data_nxt = IDLE_WORD;
        if (w_state_nxt == S_OWNED) begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_owner_nxt == IW'(i))
                    w_disp_data_nxt = bus.req_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= PTR_RESET;
            r_dwell     <= '0;
            r_disp_data <= IDLE_WORD;
            r_switch    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_dwell     <= w_dwell_nxt;
            r_disp_data <= w_disp_data_nxt;
            r_switch    <= w_switch_nxt;
        end
    end

    assign bus.grant        = w_owner_oh;
    assign bus.owner_id     = r_owner;
    assign bus.disp_data    = r_disp_data;
    assign bus.disp_valid   = (r_state == S_OWNED);
    assign bus.switch_pulse = r_switch;
endmodule
